// File: rtl/button_stepper.sv
// rtl/button_stepper.sv - Up/down push-button stepper with hold-delay auto-repeat
// and saturating bounds.
module button_stepper #(
   parameter int WIDTH       = 16,
   parameter int INIT        = 0,
   parameter int STEP        = 1,
   parameter int MIN_VAL     = 0,
   parameter int MAX_VAL     = 1000,
   parameter int HOLD_TIME   = 50000000,
   parameter int REPEAT_TIME = 5000000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_btn_up,
   input  logic             i_btn_down,
   output logic [WIDTH-1:0] o_value,
   output logic             o_change,
   output logic             o_at_min,
   output logic             o_at_max
);

   localparam logic [WIDTH:0]   MIN_W    = (WIDTH+1)'(MIN_VAL);
   localparam logic [WIDTH:0]   MAX_W    = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] MIN_N    = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_N    = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] STEP_N   = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] INIT_N   = WIDTH'(INIT);
   localparam logic [31:0]      HOLD_LIM = 32'(HOLD_TIME - 1);
   localparam logic [31:0]      REP_LIM  = 32'(REPEAT_TIME - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_HOLD,
      S_REPEAT,
      S_WAIT_RELEASE
   } state_t;

   state_t      state;
   logic [31:0] r_cnt;
   logic        r_dir;
   logic        r_up_q;
   logic        r_down_q;

   logic             up_press;
   logic             down_press;
   logic             lat_low;
   logic             opp_low;
   logic             timer_hit;
   logic             step_fire;
   logic             step_down;
   logic [WIDTH-1:0] up_next;
   logic [WIDTH-1:0] dn_next;
   logic [WIDTH-1:0] next_val;

   assign up_press   = !i_btn_up && r_up_q;
   assign down_press = !i_btn_down && r_down_q;
   assign lat_low    = r_dir ? !i_btn_down : !i_btn_up;
   assign opp_low    = r_dir ? !i_btn_up : !i_btn_down;
   assign timer_hit  = (state == S_WAIT_HOLD) ? (r_cnt == HOLD_LIM) : (r_cnt == REP_LIM);

   // Bound tests use one extra bit so value+STEP cannot overflow before comparing
   assign up_next  = (({1'b0, o_value} + STEP_W) > MAX_W) ? MAX_N : o_value + STEP_N;
   assign dn_next  = ({1'b0, o_value} < (MIN_W + STEP_W)) ? MIN_N : o_value - STEP_N;
   assign next_val = step_down ? dn_next : up_next;

   always_comb begin
      step_fire = 1'b0;
      step_down = r_dir;
      case (state)
         S_IDLE: begin
            step_down = down_press;
            step_fire = (up_press && i_btn_down) || (down_press && i_btn_up);
         end
         S_WAIT_HOLD, S_REPEAT: step_fire = lat_low && !opp_low && timer_hit;
         default: step_fire = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= S_IDLE;
         r_cnt    <= 32'd0;
         r_dir    <= 1'b0;
         r_up_q   <= 1'b1;
         r_down_q <= 1'b1;
         o_value  <= INIT_N;
         o_change <= 1'b0;
         o_at_min <= (INIT_N == MIN_N);
         o_at_max <= (INIT_N == MAX_N);
      end else begin
         r_up_q   <= i_btn_up;
         r_down_q <= i_btn_down;
         o_change <= 1'b0;
         if (step_fire) begin
            o_value  <= next_val;
            o_change <= (next_val != o_value);
            o_at_min <= (next_val == MIN_N);
            o_at_max <= (next_val == MAX_N);
         end
         case (state)
            S_IDLE: begin
               r_cnt <= 32'd0;
               if ((!i_btn_up && !i_btn_down) || (up_press && down_press)) begin
                  state <= S_WAIT_RELEASE;
               end else if (up_press) begin
                  r_dir <= 1'b0;
                  state <= S_WAIT_HOLD;
               end else if (down_press) begin
                  r_dir <= 1'b1;
                  state <= S_WAIT_HOLD;
               end
            end
            S_WAIT_HOLD, S_REPEAT: begin
               // Release wins over a timer step landing on the same edge
               if (!lat_low) begin
                  state <= S_IDLE;
                  r_cnt <= 32'd0;
               end else if (opp_low) begin
                  state <= S_WAIT_RELEASE;
                  r_cnt <= 32'd0;
               end else if (timer_hit) begin
                  state <= S_REPEAT;
                  r_cnt <= 32'd0;
               end else if (r_cnt != 32'hFFFF_FFFF) begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_WAIT_RELEASE: begin
               r_cnt <= 32'd0;
               if (i_btn_up && i_btn_down) state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               r_cnt <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_stepper.sv
// tb/tb_button_stepper.sv - Directed-vector bench for button_stepper.
module tb_button_stepper;

   logic        i_clk;
   logic        i_reset;
   logic        i_btn_up;
   logic        i_btn_down;
   logic [15:0] o_value;
   logic        o_change;
   logic        o_at_min;
   logic        o_at_max;

   int n_vec = 0;
   int n_err = 0;

   button_stepper #(
      .WIDTH(16), .INIT(10), .STEP(3), .MIN_VAL(0), .MAX_VAL(20),
      .HOLD_TIME(10), .REPEAT_TIME(4)
   ) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_btn_up   (i_btn_up),
      .i_btn_down (i_btn_down),
      .o_value    (o_value),
      .o_change   (o_change),
      .o_at_min   (o_at_min),
      .o_at_max   (o_at_max)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step_clk(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      i_btn_up   = 1'b1;
      i_btn_down = 1'b1;
      i_reset    = 1'b0;
      step_clk(2);
      i_reset = 1'b1;
      step_clk(1);
   endtask

   // Press one button for low_cycles edges, then release for 3 edges; count change pulses
   task automatic tap(input bit down, input int low_cycles, output int pulses);
      pulses = 0;
      if (down) i_btn_down = 1'b0;
      else      i_btn_up   = 1'b0;
      repeat (low_cycles) begin
         step_clk(1);
         pulses += int'(o_change);
      end
      i_btn_up   = 1'b1;
      i_btn_down = 1'b1;
      repeat (3) begin
         step_clk(1);
         pulses += int'(o_change);
      end
   endtask

   initial begin
      int pulses;
      int v;
      int exp_chg;

      // Reset state
      i_reset    = 1'b0;
      i_btn_up   = 1'b1;
      i_btn_down = 1'b1;
      step_clk(2);
      check("rst_value", o_value, 10);
      check("rst_change", o_change, 0);
      check("rst_at_min", o_at_min, 0);
      check("rst_at_max", o_at_max, 0);
      i_reset = 1'b1;
      step_clk(2);
      check("idle_value", o_value, 10);

      // Single up tap, low for 3 edges
      i_btn_up = 1'b0;
      step_clk(1);
      check("tap_value", o_value, 13);
      check("tap_change", o_change, 1);
      step_clk(1);
      check("tap_pulse_len", o_change, 0);
      step_clk(1);
      i_btn_up = 1'b1;
      pulses = 0;
      repeat (15) begin
         step_clk(1);
         pulses += int'(o_change);
      end
      check("tap_no_more", pulses, 0);
      check("tap_hold_val", o_value, 13);

      // Hold up for 31 edges from 10: steps at 0,10,14,18 then saturated
      do_reset();
      i_btn_up = 1'b0;
      v = 10;
      for (int k = 0; k <= 30; k++) begin
         exp_chg = 0;
         if (k == 0 || k == 10 || (k >= 14 && (k - 10) % 4 == 0)) begin
            if (v != 20) exp_chg = 1;
            v = (v + 3 > 20) ? 20 : v + 3;
         end
         step_clk(1);
         check($sformatf("hold_val_e%0d", k), o_value, v);
         check($sformatf("hold_chg_e%0d", k), o_change, exp_chg);
      end
      check("hold_at_max", o_at_max, 1);
      check("hold_at_min", o_at_min, 0);
      i_btn_up = 1'b1;
      step_clk(2);

      // Down taps from 10 to 4, then to 1 and 0, then no change at MIN
      do_reset();
      tap(1'b1, 2, pulses);
      tap(1'b1, 2, pulses);
      check("dn_to_4", o_value, 4);
      tap(1'b1, 2, pulses);
      check("dn_to_1", o_value, 1);
      check("dn_to_1_pulses", pulses, 1);
      tap(1'b1, 2, pulses);
      check("dn_to_0", o_value, 0);
      check("dn_to_0_pulses", pulses, 1);
      check("dn_at_min", o_at_min, 1);
      tap(1'b1, 2, pulses);
      check("dn_sat_value", o_value, 0);
      check("dn_sat_pulses", pulses, 0);

      // Both pressed on the same edge: frozen until both released
      do_reset();
      i_btn_up   = 1'b0;
      i_btn_down = 1'b0;
      pulses = 0;
      repeat (20) begin
         step_clk(1);
         pulses += int'(o_change);
      end
      check("both_pulses", pulses, 0);
      check("both_value", o_value, 10);
      i_btn_up   = 1'b1;
      i_btn_down = 1'b1;
      step_clk(2);
      tap(1'b0, 2, pulses);
      check("both_after_val", o_value, 13);
      check("both_after_pulses", pulses, 1);

      // Down pressed while up is in its hold delay
      i_btn_up = 1'b0;
      step_clk(1);
      check("opp_first_step", o_value, 16);
      step_clk(2);
      i_btn_down = 1'b0;
      pulses = 0;
      repeat (20) begin
         step_clk(1);
         pulses += int'(o_change);
      end
      i_btn_down = 1'b1;
      repeat (10) begin
         step_clk(1);
         pulses += int'(o_change);
      end
      check("opp_pulses", pulses, 0);
      check("opp_value", o_value, 16);
      i_btn_up = 1'b1;
      step_clk(2);
      tap(1'b1, 2, pulses);
      check("opp_after_val", o_value, 13);
      check("opp_after_pulses", pulses, 1);

      // Reset in the middle of an up-hold, button still held on release
      do_reset();
      i_btn_up = 1'b0;
      step_clk(1);
      check("mid_first", o_value, 13);
      step_clk(11);
      check("mid_before_rst", o_value, 16);
      i_reset = 1'b0;
      #1;
      check("mid_async_val", o_value, 10);
      check("mid_async_chg", o_change, 0);
      step_clk(1);
      check("mid_in_rst_val", o_value, 10);
      i_reset = 1'b1;
      step_clk(1);
      check("mid_repress_val", o_value, 13);
      check("mid_repress_chg", o_change, 1);
      for (int k = 1; k <= 10; k++) begin
         step_clk(1);
         check($sformatf("mid_chg_e%0d", k), o_change, (k == 10) ? 1 : 0);
      end
      check("mid_second_val", o_value, 16);
      i_btn_up = 1'b1;
      step_clk(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
